// File: rtl/Global.sv
// rtl/Global.sv - shared datapath width for the arithmetic blocks
package Global;
    parameter int DW = 8;
endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential signed restoring divider, one quotient bit per clock
module seq_divider #(
    parameter int DW = Global::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          ready,
    output logic [DW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);
    localparam int CW = (DW > 2) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic          start_q;
    logic          shot;
    logic          accept;
    logic [CW-1:0] counter;
    logic [DW-1:0] dvd;
    logic [DW-1:0] rem;
    logic [DW-1:0] dsr;
    logic          sign_q;
    logic          sign_r;
    logic          dz;
    logic [DW-1:0] a_mag;
    logic [DW-1:0] b_mag;
    logic [DW:0]   rem_shift;
    logic [DW:0]   trial;
    logic          divisor_zero;

    assign shot         = start & ~start_q;
    assign accept       = shot && (state == IDLE || state == DONE);
    assign divisor_zero = (divisor == '0);

    // -2^(DW-1) negates to itself, which read unsigned is the correct magnitude
    assign a_mag = dividend[DW-1] ? -dividend : dividend;
    assign b_mag = divisor[DW-1]  ? -divisor  : divisor;

    // rem < |divisor| always, so it fits DW bits; only the shifted trial needs DW+1
    assign rem_shift = {rem, dvd[DW-1]};
    assign trial     = rem_shift - {1'b0, dsr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (shot) state_next = divisor_zero ? FIX : ITER;
            ITER:       if (counter == CW'(DW - 1)) state_next = FIX;
            FIX:        state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q     <= 1'b0;
            counter     <= '0;
            dvd         <= '0;
            rem         <= '0;
            dsr         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            ready       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            start_q <= start;
            if (accept) begin
                // divide-by-zero preloads the FIX inputs so it yields all ones and the dividend
                dvd     <= divisor_zero ? '1 : a_mag;
                rem     <= divisor_zero ? a_mag : '0;
                dsr     <= b_mag;
                sign_q  <= divisor_zero ? 1'b0 : (dividend[DW-1] ^ divisor[DW-1]);
                sign_r  <= dividend[DW-1];
                dz      <= divisor_zero;
                counter <= '0;
                ready   <= 1'b0;
            end else if (state == ITER) begin
                rem     <= trial[DW] ? rem_shift[DW-1:0] : trial[DW-1:0];
                dvd     <= {dvd[DW-2:0], ~trial[DW]};
                counter <= counter + CW'(1);
            end else if (state == FIX) begin
                quotient    <= sign_q ? -dvd : dvd;
                remainder   <= sign_r ? -rem : rem;
                div_by_zero <= dz;
                ready       <= 1'b1;
            end
        end
    end
endmodule
